// File: rtl/mem_load_verify_if.sv
// Handshake, memory-bus and control/status bundle between the load/verify
// sequencer and its controller, upstream data source and the masked-write memory.
interface mem_load_verify_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_rd_data;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   ro_err_cnt;
    logic [AW-1:0] first_err_addr;

    modport master (
        output start, in_valid, in_data, mem_rd_data,
        input  in_ready, mem_wr, mem_addr, mem_data, busy, done, err,
               ro_err_cnt, first_err_addr
    );

    modport slave (
        input  start, in_valid, in_data, mem_rd_data,
        output in_ready, mem_wr, mem_addr, mem_data, busy, done, err,
               ro_err_cnt, first_err_addr
    );
endinterface

// File: rtl/mem_load_verify.sv
// Loads DEP words into the masked-write memory, reads them all back and flags
// write-protected bits that misread or a readback checksum that disagrees.
module mem_load_verify #(
    parameter int            DW      = 8,
    parameter int            AW      = 4,
    parameter int            DEP     = 16,
    parameter logic [DW-1:0] MASK    = 8'h5F,
    parameter logic [DW-1:0] DEFU    = 8'hFF,
    parameter int            WR_HOLD = 2
) (
    input  logic               clk,
    input  logic               rst,
    mem_load_verify_if.slave   bus
);
    localparam int SW = AW + DW;
    localparam int CW = AW + 1;
    localparam int HW = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEP - 1);
    localparam logic [HW-1:0] LAST_HOLD = HW'(WR_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ACCEPT, S_WRITE, S_SETTLE, S_RD_WAIT, S_CHECK, S_FINISH
    } state_t;

    // Word the memory will hold once its protected bits are forced to default.
    function automatic logic [DW-1:0] stored_word(input logic [DW-1:0] d);
        return (d & MASK) | (DEFU & ~MASK);
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (&c) ? c : c + CW'(1);
    endfunction

    state_t        state_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic [HW-1:0] hold_q;
    logic          wr_q;
    logic          rdy_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic [CW-1:0] ro_cnt_q;
    logic [AW-1:0] first_q;
    logic [SW-1:0] exp_sum_q;
    logic [SW-1:0] rd_sum_q;

    logic          ro_bad;
    logic [CW-1:0] ro_cnt_d;
    logic [SW-1:0] exp_sum_d;
    logic [SW-1:0] rd_sum_d;

    assign ro_bad    = (bus.mem_rd_data & ~MASK) != (DEFU & ~MASK);
    assign ro_cnt_d  = ro_bad ? sat_inc(ro_cnt_q) : ro_cnt_q;
    assign exp_sum_d = exp_sum_q + {{AW{1'b0}}, stored_word(bus.in_data)};
    assign rd_sum_d  = rd_sum_q + {{AW{1'b0}}, bus.mem_rd_data};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            hold_q    <= '0;
            wr_q      <= 1'b0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ro_cnt_q  <= '0;
            first_q   <= '0;
            exp_sum_q <= '0;
            rd_sum_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        err_q     <= 1'b0;
                        ro_cnt_q  <= '0;
                        first_q   <= '0;
                        exp_sum_q <= '0;
                        rd_sum_q  <= '0;
                        busy_q    <= 1'b1;
                        addr_q    <= '0;
                        rdy_q     <= 1'b1;
                        state_q   <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (bus.in_valid && rdy_q) begin
                        data_q    <= bus.in_data;
                        exp_sum_q <= exp_sum_d;
                        rdy_q     <= 1'b0;
                        wr_q      <= 1'b1;
                        hold_q    <= '0;
                        state_q   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (hold_q == LAST_HOLD) begin
                        wr_q <= 1'b0;
                        if (addr_q == LAST_ADDR) begin
                            addr_q  <= '0;
                            state_q <= S_SETTLE;
                        end else begin
                            addr_q  <= addr_q + AW'(1);
                            rdy_q   <= 1'b1;
                            state_q <= S_ACCEPT;
                        end
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                S_SETTLE:  state_q <= S_RD_WAIT;
                S_RD_WAIT: state_q <= S_CHECK;
                S_CHECK: begin
                    rd_sum_q <= rd_sum_d;
                    ro_cnt_q <= ro_cnt_d;
                    if (ro_bad && (ro_cnt_q == '0)) first_q <= addr_q;
                    // Verdict uses the just-updated totals so it is valid with done.
                    if (addr_q == LAST_ADDR) begin
                        err_q   <= (rd_sum_d != exp_sum_q) || (ro_cnt_d != '0);
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end else begin
                        addr_q  <= addr_q + AW'(1);
                        state_q <= S_RD_WAIT;
                    end
                end
                S_FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready       = rdy_q;
    assign bus.mem_wr         = wr_q;
    assign bus.mem_addr       = addr_q;
    assign bus.mem_data       = data_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.err            = err_q;
    assign bus.ro_err_cnt     = ro_cnt_q;
    assign bus.first_err_addr = first_q;
endmodule
